// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared definitions for the VGA rectangle compositor:
//   - default 640x480@60 timing constants (800x521 total, 25 MHz dclk)
//   - coordinate widths (X_W for px, Y_W for py, CNT_W for the raw counters)
//   - rgb332_t colour type and the per-layer rect_t shadow record
//   - colour-bar palette used when VGA_COLORBARS_EN is defined
// -----------------------------------------------------------------------------
package vga_pkg;

  // Default timing, in dclk cycles (horizontal) and lines (vertical).
  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned V_TOTAL_DEF = 521;
  localparam int unsigned H_PULSE_DEF = 96;
  localparam int unsigned V_PULSE_DEF = 2;
  localparam int unsigned H_BP_DEF    = 144;
  localparam int unsigned H_FP_DEF    = 784;
  localparam int unsigned V_BP_DEF    = 31;
  localparam int unsigned V_FP_DEF    = 511;

  // Counter and coordinate widths. Totals must not exceed 1024.
  localparam int unsigned CNT_W = 10;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  typedef logic [7:0] rgb332_t;

  // One captured rectangle layer.
  typedef struct packed {
    logic           en;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    rgb332_t        color;
  } rect_t;

  // Colour-bar test pattern, left to right.
  localparam int NUM_BARS = 8;

  function automatic rgb332_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 8'hFF;  // white
      3'd1:    bar_color = 8'hFC;  // yellow
      3'd2:    bar_color = 8'h1F;  // cyan
      3'd3:    bar_color = 8'h1C;  // green
      3'd4:    bar_color = 8'hE3;  // magenta
      3'd5:    bar_color = 8'hE0;  // red
      3'd6:    bar_color = 8'h03;  // blue
      default: bar_color = 8'h00;  // black
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Free-running horizontal/vertical counters and everything derived directly
// from the current counter state. All outputs are combinational views of the
// counter registers; the caller registers them.
//
// Ports:
//   dclk        in   pixel clock
//   rst_n       in   asynchronous active-low reset (counters to 0,0)
//   hsync_raw   out  hc >= H_PULSE (active-low sync, unregistered)
//   vsync_raw   out  vc >= V_PULSE
//   active      out  counter state lies inside the visible area
//   px          out  hc - H_BP (valid only when active)
//   py          out  vc - V_BP, CNT_W wide (valid only when active)
//   frame_first out  state is hc=0, vc=0
//   frame_end   out  state is the last cycle of the frame
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned H_PULSE = H_PULSE_DEF,
  parameter int unsigned V_PULSE = V_PULSE_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned V_BP    = V_BP_DEF,
  parameter int unsigned V_FP    = V_FP_DEF
) (
  input  logic             dclk,
  input  logic             rst_n,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             active,
  output logic [X_W-1:0]   px,
  output logic [CNT_W-1:0] py,
  output logic             frame_first,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_PULSE_C = CNT_W'(H_PULSE);
  localparam logic [CNT_W-1:0] V_PULSE_C = CNT_W'(V_PULSE);
  localparam logic [CNT_W-1:0] H_BP_C    = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] H_FP_C    = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] V_BP_C    = CNT_W'(V_BP);
  localparam logic [CNT_W-1:0] V_FP_C    = CNT_W'(V_FP);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hsync_raw   = (hc_q >= H_PULSE_C);
  assign vsync_raw   = (vc_q >= V_PULSE_C);
  assign active      = (hc_q >= H_BP_C) && (hc_q < H_FP_C) &&
                       (vc_q >= V_BP_C) && (vc_q < V_FP_C);
  assign px          = hc_q - H_BP_C;
  // py is kept counter-wide so it compares against 10-bit y+h sums directly.
  assign py          = vc_q - V_BP_C;
  assign frame_first = (hc_q == '0) && (vc_q == '0);
  assign frame_end   = (hc_q == H_LAST) && (vc_q == V_LAST);

endmodule

// File: rtl/vga_rect_compositor.sv
// -----------------------------------------------------------------------------
// vga_rect_compositor
//
// VGA timing generator plus an NRECT-layer filled-rectangle compositor driving
// an RGB332 DAC. Rectangle inputs are shadow-latched on the last cycle of each
// frame, so they may change at any time without tearing; the hit test only
// ever sees the shadows. Every output is registered from the same counter
// state, giving one dclk of latency and mutual alignment.
//
// Optional build macro: VGA_COLORBARS_EN replaces the background with eight
// vertical colour bars (bg_color is then ignored).
//
// Ports:
//   dclk         in   pixel clock (25 MHz at default timing)
//   rst_n        in   asynchronous active-low reset
//   rect_en      in   per-layer enable, bit i = layer i
//   rect_x       in   left edge,  layer i at [10*i+9:10*i]
//   rect_y       in   top edge,   layer i at [9*i+8:9*i]
//   rect_w       in   width  (0 draws nothing)
//   rect_h       in   height (0 draws nothing)
//   rect_color   in   RGB332 fill, layer i at [8*i+7:8*i]
//   bg_color     in   RGB332 background of the active area
//   hsync/vsync  out  active-low syncs
//   red/green/blue out colour (3/3/2 bits)
//   frame_start  out  one-cycle pulse on the output cycle of hc=0, vc=0
//
// NRECT must lie in 1..8; layer 0 has the highest priority.
// -----------------------------------------------------------------------------
module vga_rect_compositor
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned H_PULSE = H_PULSE_DEF,
  parameter int unsigned V_PULSE = V_PULSE_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned V_BP    = V_BP_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned NRECT   = 4
) (
  input  logic                 dclk,
  input  logic                 rst_n,
  input  logic [NRECT-1:0]     rect_en,
  input  logic [NRECT*X_W-1:0] rect_x,
  input  logic [NRECT*Y_W-1:0] rect_y,
  input  logic [NRECT*X_W-1:0] rect_w,
  input  logic [NRECT*Y_W-1:0] rect_h,
  input  logic [NRECT*8-1:0]   rect_color,
  input  logic [7:0]           bg_color,
  output logic                 hsync,
  output logic                 vsync,
  output logic [2:0]           red,
  output logic [2:0]           green,
  output logic [1:0]           blue,
  output logic                 frame_start
);

  // ---------------------------------------------------------------------------
  // Timing
  // ---------------------------------------------------------------------------
  logic             hsync_raw, vsync_raw, active, frame_first, frame_end;
  logic [X_W-1:0]   px;
  logic [CNT_W-1:0] py;

  vga_timing #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_PULSE (H_PULSE),
    .V_PULSE (V_PULSE),
    .H_BP    (H_BP),
    .H_FP    (H_FP),
    .V_BP    (V_BP),
    .V_FP    (V_FP)
  ) u_timing (
    .dclk        (dclk),
    .rst_n       (rst_n),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .active      (active),
    .px          (px),
    .py          (py),
    .frame_first (frame_first),
    .frame_end   (frame_end)
  );

  // ---------------------------------------------------------------------------
  // Shadow registers: reload from the inputs only on the frame-end edge.
  // ---------------------------------------------------------------------------
  rect_t shadow_q [NRECT];
  rect_t shadow_d [NRECT];

  always_comb begin
    for (int i = 0; i < NRECT; i++) begin
      shadow_d[i] = shadow_q[i];
      if (frame_end) begin
        shadow_d[i].en    = rect_en[i];
        shadow_d[i].x     = rect_x[X_W*i +: X_W];
        shadow_d[i].y     = rect_y[Y_W*i +: Y_W];
        shadow_d[i].w     = rect_w[X_W*i +: X_W];
        shadow_d[i].h     = rect_h[Y_W*i +: Y_W];
        shadow_d[i].color = rect_color[8*i +: 8];
      end
    end
  end

  // NOTE: this register array is reset on purpose: after reset every layer
  // must read as disabled until the first capture, so the enables cannot be
  // left to power-up values the way a plain data memory could be.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRECT; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < NRECT; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Hit test. Right/bottom sums are one bit wider than the operands so a large
  // w or h can never wrap back onto the screen; clipping at the screen edge
  // falls out of gating with 'active'.
  // ---------------------------------------------------------------------------
  logic [NRECT-1:0] hit;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    hit = '0;
    for (int i = 0; i < NRECT; i++) begin
      hit[i] = shadow_q[i].en &&
               ({1'b0, px} >= {1'b0, shadow_q[i].x}) &&
               ({1'b0, px} <  ({1'b0, shadow_q[i].x} + {1'b0, shadow_q[i].w})) &&
               (py >= {1'b0, shadow_q[i].y}) &&
               (py <  ({1'b0, shadow_q[i].y} + {1'b0, shadow_q[i].h}));
    end
  end

  // ---------------------------------------------------------------------------
  // Background source
  // ---------------------------------------------------------------------------
  rgb332_t bg_fill;

`ifdef VGA_COLORBARS_EN
  localparam int BAR_W = int'((H_FP - H_BP) / NUM_BARS);
  logic [2:0] bar_idx;

  // Threshold compare instead of a divide; leftover pixels when the active
  // width is not a multiple of eight extend the last (black) bar.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (int'(px) >= k * BAR_W) bar_idx = 3'(k);
    end
  end

  assign bg_fill = bar_color(bar_idx);
`else
  assign bg_fill = bg_color;
`endif

  // ---------------------------------------------------------------------------
  // Priority: walk from the highest index down so the lowest hitting layer is
  // the last assignment and wins.
  // ---------------------------------------------------------------------------
  rgb332_t pix_color;

  always_comb begin
    pix_color = bg_fill;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (hit[i]) pix_color = shadow_q[i].color;
    end
    if (!active) pix_color = '0;
  end

  // ---------------------------------------------------------------------------
  // Output register: everything from the same counter state.
  // ---------------------------------------------------------------------------
  logic    hsync_q, vsync_q, frame_start_q;
  rgb332_t color_q;

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      color_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_raw;
      vsync_q       <= vsync_raw;
      color_q       <= pix_color;
      frame_start_q <= frame_first;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = color_q[7:5];
  assign green       = color_q[4:2];
  assign blue        = color_q[1:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_rect_compositor.sv
// -----------------------------------------------------------------------------
// tb_vga_rect_compositor
//
// Runs the compositor with a shrunken raster (40x30 total, 28x24 active) so
// many frames fit in a short run. A behavioural model computes, for every
// output cycle, the expected {hsync, vsync, frame_start, rgb} directly from
// the cycle count since reset and a copy of the rectangle set captured at
// each frame end. Directed layer setups are followed by random ones, each
// applied at a random point mid-frame, and a reset is asserted mid-frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_rect_compositor;

  localparam int HT = 40, VT = 30, HP = 4, VP = 2;
  localparam int HBP = 8, HFP = 36, VBP = 3, VFP = 27;
  localparam int NR = 4;
  localparam int FRAME = HT * VT;

  logic             dclk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    rect_en;
  logic [NR*10-1:0] rect_x, rect_w;
  logic [NR*9-1:0]  rect_y, rect_h;
  logic [NR*8-1:0]  rect_color;
  logic [7:0]       bg_color;
  logic             hsync, vsync, frame_start;
  logic [2:0]       red, green;
  logic [1:0]       blue;

  vga_rect_compositor #(
    .H_TOTAL (HT), .V_TOTAL (VT), .H_PULSE (HP), .V_PULSE (VP),
    .H_BP (HBP), .H_FP (HFP), .V_BP (VBP), .V_FP (VFP), .NRECT (NR)
  ) dut (
    .dclk        (dclk),
    .rst_n       (rst_n),
    .rect_en     (rect_en),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_color  (rect_color),
    .bg_color    (bg_color),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start)
  );

  always #5 dclk = ~dclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: rectangle set as seen by the hit test.
  // ---------------------------------------------------------------------------
  int s_en [NR], s_x [NR], s_y [NR], s_w [NR], s_h [NR], s_c [NR];
  int k;  // counter state index registered by the next clock edge

  task automatic clear_shadow();
    for (int i = 0; i < NR; i++) begin
      s_en[i] = 0; s_x[i] = 0; s_y[i] = 0; s_w[i] = 0; s_h[i] = 0; s_c[i] = 0;
    end
  endtask

  task automatic capture();
    for (int i = 0; i < NR; i++) begin
      s_en[i] = int'(rect_en[i]);
      s_x[i]  = int'(rect_x[i*10 +: 10]);
      s_y[i]  = int'(rect_y[i*9 +: 9]);
      s_w[i]  = int'(rect_w[i*10 +: 10]);
      s_h[i]  = int'(rect_h[i*9 +: 9]);
      s_c[i]  = int'(rect_color[i*8 +: 8]);
    end
  endtask

  function automatic int bar_ref(int px);
    int bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    int idx = px / ((HFP - HBP) / 8);
    if (idx > 7) idx = 7;
    return bars[idx];
  endfunction

  // Expected {hsync, vsync, frame_start, colour[7:0]} for counter state n.
  function automatic logic [10:0] model(int n);
    int hc = n % HT;
    int vc = (n / HT) % VT;
    int col = 0;
    logic hs = (hc >= HP);
    logic vs = (vc >= VP);
    logic fs = (hc == 0 && vc == 0);
    if (hc >= HBP && hc < HFP && vc >= VBP && vc < VFP) begin
      int px = hc - HBP;
      int py = vc - VBP;
      bit found = 0;
`ifdef VGA_COLORBARS_EN
      col = bar_ref(px);
`else
      col = int'(bg_color);
`endif
      for (int i = 0; i < NR; i++) begin
        if (!found && s_en[i] != 0 && px >= s_x[i] && px < s_x[i] + s_w[i] &&
            py >= s_y[i] && py < s_y[i] + s_h[i]) begin
          col = s_c[i];
          found = 1;
        end
      end
    end
    return {hs, vs, fs, 8'(col)};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_layer(int i, int en, int x, int y, int w, int h, int c);
    rect_en[i]            = en[0];
    rect_x[i*10 +: 10]    = 10'(x);
    rect_y[i*9 +: 9]      = 9'(y);
    rect_w[i*10 +: 10]    = 10'(w);
    rect_h[i*9 +: 9]      = 9'(h);
    rect_color[i*8 +: 8]  = 8'(c);
  endtask

  task automatic apply_cfg(int id);
    case (id)
      1: begin  // single corner pixel
        bg_color = 8'h55;
        set_layer(0, 1, 0, 0, 1, 1, 8'hE0);
        for (int i = 1; i < NR; i++) set_layer(i, 0, 0, 0, 0, 0, 0);
      end
      2: begin  // overlap priority, exclusive right/bottom edges
        bg_color = 8'h49;
        set_layer(0, 1, 4, 4, 6, 6, 8'h1C);
        set_layer(1, 1, 0, 0, HFP - HBP, VFP - VBP, 8'h03);
        set_layer(2, 0, 0, 0, 0, 0, 0);
        set_layer(3, 0, 0, 0, 0, 0, 0);
      end
      3: begin  // clipping, zero sizes, maximum extents
        bg_color = 8'hB6;
        set_layer(0, 1, 25, 5, 10, 3, 8'hE0);
        set_layer(1, 1, 2, 2, 0, 5, 8'hFF);
        set_layer(2, 1, 2, 2, 5, 0, 8'hFF);
        set_layer(3, 1, 27, 23, 1023, 511, 8'h92);
      end
      4: begin  // random
        bg_color = 8'($urandom);
        for (int i = 0; i < NR; i++) begin
          int w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
          int h = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
          if ($urandom_range(0, 9) == 0) w = 1023;
          set_layer(i, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 30)), w, h, int'($urandom_range(0, 255)));
        end
      end
      default: ;
    endcase
  endtask

  // One output cycle: predict, advance the model, then sample #1 after the edge.
  task automatic step();
    logic [10:0] exp;
    @(posedge dclk);
    exp = model(k);
    if ((k % HT) == HT - 1 && ((k / HT) % VT) == VT - 1) capture();
    k++;
    #1;
    check($sformatf("pix k=%0d", k - 1), {21'b0, hsync, vsync, frame_start, red, green, blue},
          {21'b0, exp});
  endtask

  // Run n cycles; apply configuration id after sampling cycle 'off'.
  task automatic run(int n, int id, int off);
    for (int c = 0; c < n; c++) begin
      step();
      if (c == off) apply_cfg(id);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check(tag, {24'b0, hsync, vsync, frame_start, red, green, blue}, {24'b0, 3'b110, 8'h00});
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1;
    rect_en = '0; rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
    rect_color = '0; bg_color = 8'h24;
    clear_shadow();
    k = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_initial");
    repeat (3) @(posedge dclk);
    #1 check_reset_outputs("reset_held");
    @(negedge dclk) rst_n = 1'b1;

    // Frame 0 shows only background; setups then each appear one frame late.
    run(FRAME, 1, FRAME / 2);
    run(FRAME, 2, int'($urandom_range(0, FRAME - 1)));
    run(FRAME, 3, HT * 12 + 5);
    run(FRAME, 4, FRAME - 2);  // change lands just before the capture edge
    for (int f = 0; f < 10; f++) begin
      int off;
      case ($urandom_range(0, 4))
        0:       off = FRAME - 2;
        1:       off = FRAME - 1;
        default: off = int'($urandom_range(0, FRAME - 1));
      endcase
      run(FRAME, 4, off);
    end

    // Mid-frame asynchronous reset, checked before any further clock edge.
    run(HT * (VT / 2) + 7, 0, -1);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_midframe");
    clear_shadow();
    k = 0;
    repeat (2) @(posedge dclk);
    #1 check_reset_outputs("reset_midframe_held");
    @(negedge dclk) rst_n = 1'b1;

    // Inputs still hold the last setup; it must not draw until after capture.
    run(FRAME, 0, -1);
    run(FRAME, 4, FRAME / 3);
    run(FRAME, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
